array_seq_muldiv: RTL

- Sequential, handshaked multiply/divide engine on the same operand/result format as the combinational array6 datapath: L dividend/multiplicand, B divisor/multiplier, Z mode select.
- Accepts one request through a valid/ready command port.
- Computes iteratively: shift-add for multiply, restoring shift-subtract for divide.
- Returns product, quotient and remainder through a valid/ready response port.
- Acts as the requester-facing end of the array datapath for multi-cycle, backpressured systems.

---
 rtl/array_seq_muldiv.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/array_seq_muldiv.sv
// array_seq_muldiv
// ----------------
// Sequential multiply/divide engine with valid/ready request and response
// ports. Multiply is shift-add, one multiplier bit per clock, LSB first.
// Divide is restoring shift-subtract, one quotient bit per clock, MSB first.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    command handshake; req_ready is high only in IDLE
//   Z                  mode: 1 = divide, 0 = multiply
//   L [LW]             dividend / multiplicand
//   B [BW]             divisor / multiplier
//   rsp_valid/ready    response handshake
//   Mul_out [LW]       low LW bits of L*B (multiply mode, else 0)
//   Divider_out [LW]   L/B (divide mode, else 0; all ones on divide by zero)
//   remainder [BW]     L mod B (divide mode, else 0; L[BW-1:0] on divide by zero)
//   mul_ovf            product does not fit in LW bits
//   div_zero           divide request with B == 0
//   busy               engine not idle
module array_seq_muldiv #(
   parameter int LW = 8,
   parameter int BW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          Z,
   input  logic [LW-1:0] L,
   input  logic [BW-1:0] B,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [LW-1:0] Mul_out,
   output logic [LW-1:0] Divider_out,
   output logic [BW-1:0] remainder,
   output logic          mul_ovf,
   output logic          div_zero,
   output logic          busy
);

   localparam int CW = $clog2(LW) + 1;
   localparam int AW = LW + BW;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t        state_q;
   logic [BW-1:0] b_q;
   logic [BW-1:0] mplr_q;      // multiplier, shifted right each step
   logic [AW-1:0] mcand_q;     // multiplicand, shifted left each step
   logic [AW-1:0] acc_q;
   logic [LW-1:0] divd_q;      // dividend, shifted left to expose next bit
   logic [LW-1:0] quo_q;
   logic [BW:0]   prem_q;      // partial remainder, one bit wider than B
   logic [CW-1:0] cnt_q;

   logic [LW-1:0] mul_out_q;
   logic [LW-1:0] div_out_q;
   logic [BW-1:0] rem_out_q;
   logic          mul_ovf_q;
   logic          div_zero_q;
   logic          rsp_valid_q;

   // Next-step datapath values for the current iteration
   logic [AW-1:0] acc_d;
   logic [BW:0]   prem_shift;
   logic          quo_bit;
   logic [BW:0]   prem_d;
   logic [LW-1:0] quo_d;

   always_comb begin
      acc_d      = acc_q + (mplr_q[0] ? mcand_q : '0);
      prem_shift = {prem_q[BW-1:0], divd_q[LW-1]};
      quo_bit    = (prem_shift >= {1'b0, b_q});
      prem_d     = quo_bit ? (prem_shift - {1'b0, b_q}) : prem_shift;
      quo_d      = {quo_q[LW-2:0], quo_bit};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         b_q         <= '0;
         mplr_q      <= '0;
         mcand_q     <= '0;
         acc_q       <= '0;
         divd_q      <= '0;
         quo_q       <= '0;
         prem_q      <= '0;
         cnt_q       <= '0;
         mul_out_q   <= '0;
         div_out_q   <= '0;
         rem_out_q   <= '0;
         mul_ovf_q   <= 1'b0;
         div_zero_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  b_q        <= B;
                  mplr_q     <= B;
                  mcand_q    <= {{BW{1'b0}}, L};
                  divd_q     <= L;
                  acc_q      <= '0;
                  quo_q      <= '0;
                  prem_q     <= '0;
                  cnt_q      <= '0;
                  mul_out_q  <= '0;
                  div_out_q  <= '0;
                  rem_out_q  <= '0;
                  mul_ovf_q  <= 1'b0;
                  div_zero_q <= 1'b0;
                  // Divide by zero also passes through DIV for one cycle so
                  // the response appears one edge after the accept.
                  state_q    <= Z ? DIV : MUL;
               end
            end
            MUL: begin
               acc_q   <= acc_d;
               mplr_q  <= mplr_q >> 1;
               mcand_q <= mcand_q << 1;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == CW'(BW - 1)) begin
                  mul_out_q   <= acc_d[LW-1:0];
                  mul_ovf_q   <= |acc_d[AW-1:LW];
                  rsp_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DIV: begin
               if (b_q == '0) begin
                  div_out_q   <= '1;
                  rem_out_q   <= divd_q[BW-1:0];   // divd_q still holds L here
                  div_zero_q  <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  prem_q <= prem_d;
                  quo_q  <= quo_d;
                  divd_q <= divd_q << 1;
                  cnt_q  <= cnt_q + 1'b1;
                  if (cnt_q == CW'(LW - 1)) begin
                     div_out_q   <= quo_d;
                     rem_out_q   <= prem_d[BW-1:0];
                     rsp_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign Mul_out     = mul_out_q;
   assign Divider_out = div_out_q;
   assign remainder   = rem_out_q;
   assign mul_ovf     = mul_ovf_q;
   assign div_zero    = div_zero_q;

endmodule
